// File: rtl/simon_pkg.sv
// simon_pkg: shared FSM state type and default palette colours for the Simon Says colour path
package simon_pkg;
  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
  localparam logic [11:0] RED    = 12'hF00;
  localparam logic [11:0] GREEN  = 12'h0F0;
  localparam logic [11:0] BLUE   = 12'h00F;
  localparam logic [11:0] YELLOW = 12'hFF0;
  localparam logic [11:0] WHITE  = 12'hFFF;
endpackage

// File: rtl/color_palette.sv
// color_palette: writable RGB lookup table with defaults restored on reset
module color_palette
  import simon_pkg::*;
#(
  parameter int COLOR_BITS = 2,
  parameter int CH_BITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [COLOR_BITS-1:0]   wrAddr,
  input  logic [3*CH_BITS-1:0]    wrData,
  input  logic [COLOR_BITS-1:0]   rdAddr,
  output logic [3*CH_BITS-1:0]    rdData
);
  localparam int ENTRIES = 2 ** COLOR_BITS;
  logic [3*CH_BITS-1:0] pal [ENTRIES];
  // Each nonzero nibble of the 12-bit default becomes a full-scale channel
  function automatic logic [3*CH_BITS-1:0] defaultColor(int idx);
    logic [11:0] base;
    logic [3*CH_BITS-1:0] rgb;
    base = idx == 0 ? RED : idx == 1 ? GREEN : idx == 2 ? BLUE : idx == 3 ? YELLOW : WHITE;
    for (int c = 0; c < 3; c++) rgb[c*CH_BITS +: CH_BITS] = {CH_BITS{base[c*4 +: 4] != 4'h0}};
    return rgb;
  endfunction
  assign rdData = pal[rdAddr];
  // Palette storage: defaults on reset, otherwise single write port
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < ENTRIES; i++) pal[i] <= defaultColor(i);
    else if (we) pal[wrAddr] <= wrData;
  end
endmodule

// File: rtl/color_sequence_player.sv
// color_sequence_player: stores colour indices and plays them back as timed palette flashes
module color_sequence_player
  import simon_pkg::*;
#(
  parameter int COLOR_BITS = 2,
  parameter int CH_BITS = 4,
  parameter int DEPTH = 32,
  parameter int ON_CYCLES = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000,
  localparam int SW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int RGBW = 3 * CH_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_valid,
  input  logic [COLOR_BITS-1:0] push_color,
  output logic                  push_ready,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  pal_we,
  input  logic [COLOR_BITS-1:0] pal_addr,
  input  logic [RGBW-1:0]       pal_data,
  output logic [RGBW-1:0]       color_out,
  output logic                  color_valid,
  output logic [SW-1:0]         step,
  output logic [CW-1:0]         count,
  output logic                  busy,
  output logic                  done
);
  localparam int MAXC = ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES;
  localparam int PW = MAXC > 1 ? $clog2(MAXC) : 1;
  state_t state;
  logic [COLOR_BITS-1:0] seq [DEPTH];
  logic [CW-1:0] seqLen;
  logic [CW-1:0] postCount;
  logic [PW-1:0] phase;
  logic [COLOR_BITS-1:0] rdAddr;
  logic [RGBW-1:0] palColor;
  logic pushOk;
  logic lastStep;
  color_palette #(.COLOR_BITS(COLOR_BITS), .CH_BITS(CH_BITS)) palette (
    .clk(clk),
    .reset(reset),
    .we(pal_we),
    .wrAddr(pal_addr),
    .wrData(pal_data),
    .rdAddr(rdAddr),
    .rdData(palColor)
  );
  // Palette lookup for the entry about to start; an empty store forwards the same-cycle push
  always_comb begin
    pushOk = push_valid && push_ready;
    postCount = count + CW'(pushOk);
    lastStep = (CW'(step) + CW'(1)) == seqLen;
    rdAddr = state == IDLE ? (count == '0 ? push_color : seq[0]) : seq[lastStep ? '0 : step + SW'(1)];
  end
  // Sequence store: append at the current count, contents survive playback
  always_ff @(posedge clk) begin
    if (pushOk && !clear && !reset) seq[count[SW-1:0]] <= push_color;
  end
  // Playback FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      seqLen <= '0;
      step <= '0;
      phase <= '0;
      color_out <= '0;
      color_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      push_ready <= 1'b1;
    end else if (clear) begin
      state <= IDLE;
      count <= '0;
      step <= '0;
      color_out <= '0;
      color_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      push_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      count <= postCount;
      case (state)
        IDLE:
          if (start && postCount != '0) begin
            state <= ON;
            seqLen <= postCount;
            step <= '0;
            phase <= PW'(ON_CYCLES - 1);
            color_out <= palColor;
            color_valid <= 1'b1;
            busy <= 1'b1;
            push_ready <= 1'b0;
          end else begin
            done <= start;
            push_ready <= postCount < CW'(DEPTH);
          end
        ON:
          if (phase == '0) begin
            state <= OFF;
            phase <= PW'(OFF_CYCLES - 1);
            color_out <= '0;
            color_valid <= 1'b0;
          end else phase <= phase - PW'(1);
        OFF:
          if (phase != '0) phase <= phase - PW'(1);
          else if (lastStep) begin
            state <= IDLE;
            done <= 1'b1;
            busy <= 1'b0;
            push_ready <= count < CW'(DEPTH);
          end else begin
            state <= ON;
            step <= step + SW'(1);
            phase <= PW'(ON_CYCLES - 1);
            color_out <= palColor;
            color_valid <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_color_sequence_player.sv
// tb_color_sequence_player: directed and randomized playback checks against a timeline model
module tb_color_sequence_player;
  localparam int DEPTH = 4;
  localparam int ONC = 3;
  localparam int OFFC = 2;
  localparam int PER = ONC + OFFC;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic push_valid = 1'b0;
  logic [1:0] push_color = '0;
  logic push_ready;
  logic clear = 1'b0;
  logic start = 1'b0;
  logic pal_we = 1'b0;
  logic [1:0] pal_addr = '0;
  logic [11:0] pal_data = '0;
  logic [11:0] color_out;
  logic color_valid;
  logic [1:0] step;
  logic [2:0] count;
  logic busy;
  logic done;
  int nAssert = 0;
  int nFail = 0;
  int mSeq[$];
  logic [11:0] mPal [4];
  color_sequence_player #(
    .COLOR_BITS(2), .CH_BITS(4), .DEPTH(DEPTH), .ON_CYCLES(ONC), .OFF_CYCLES(OFFC)
  ) dut (
    .clk(clk), .reset(reset), .push_valid(push_valid), .push_color(push_color),
    .push_ready(push_ready), .clear(clear), .start(start), .pal_we(pal_we),
    .pal_addr(pal_addr), .pal_data(pal_data), .color_out(color_out),
    .color_valid(color_valid), .step(step), .count(count), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic doReset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    mSeq.delete();
    mPal = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0};
    chk("rst_color", 32'(color_out), 32'(0));
    chk("rst_valid", 32'(color_valid), 32'(0));
    chk("rst_step", 32'(step), 32'(0));
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_ready", 32'(push_ready), 32'(1));
  endtask
  task automatic doPush(int c);
    push_valid = 1'b1;
    push_color = 2'(c);
    cyc();
    push_valid = 1'b0;
    if (mSeq.size() < DEPTH) mSeq.push_back(c);
    chk("push_count", 32'(count), 32'(mSeq.size()));
    chk("push_ready", 32'(push_ready), 32'(mSeq.size() < DEPTH));
  endtask
  task automatic palWrite(int a, logic [11:0] d);
    pal_we = 1'b1;
    pal_addr = 2'(a);
    pal_data = d;
    cyc();
    pal_we = 1'b0;
    mPal[a] = d;
  endtask
  // Playback timeline: entry k occupies cycles k*PER+1..k*PER+PER, ON first, done one cycle after the last
  task automatic play(bit withPush, int pc, int wrCycle, int wa, logic [11:0] wd);
    int len;
    int k;
    bit inPlay;
    bit inOn;
    logic [11:0] latched;
    if (withPush && mSeq.size() < DEPTH) mSeq.push_back(pc);
    push_valid = withPush;
    push_color = 2'(pc);
    start = 1'b1;
    cyc();
    push_valid = 1'b0;
    start = 1'b0;
    len = mSeq.size();
    latched = mPal[mSeq[0]];
    for (int t = 1; t <= len * PER + 1; t++) begin
      inPlay = t <= len * PER;
      k = inPlay ? (t - 1) / PER : len - 1;
      inOn = inPlay && ((t - 1) % PER) < ONC;
      chk("play_color", 32'(color_out), 32'(inOn ? latched : 12'h000));
      chk("play_valid", 32'(color_valid), 32'(inOn));
      chk("play_step", 32'(step), 32'(k));
      chk("play_busy", 32'(busy), 32'(inPlay));
      chk("play_done", 32'(done), 32'(!inPlay));
      chk("play_ready", 32'(push_ready), 32'(!inPlay && len < DEPTH));
      if (t % PER == 0 && t / PER < len) latched = mPal[mSeq[t / PER]];
      if (inPlay) begin
        if (t == wrCycle) begin
          pal_we = 1'b1;
          pal_addr = 2'(wa);
          pal_data = wd;
          mPal[wa] = wd;
        end
        cyc();
        pal_we = 1'b0;
      end
    end
  endtask
  initial begin
    int n;
    bit wp;
    doReset();
    for (int i = 0; i < 4; i++) doPush(i);
    play(1'b0, 0, 0, 0, 12'h000);
    doReset();
    for (int i = 0; i < 5; i++) doPush(i % 4);
    doReset();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("empty_done", 32'(done), 32'(1));
    chk("empty_busy", 32'(busy), 32'(0));
    chk("empty_valid", 32'(color_valid), 32'(0));
    cyc();
    chk("empty_done_clr", 32'(done), 32'(0));
    chk("empty_busy2", 32'(busy), 32'(0));
    doReset();
    doPush(2);
    doPush(3);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      chk("abort_busy", 32'(busy), 32'(1));
      chk("abort_valid", 32'(color_valid), 32'(t <= ONC));
      if (t == 4) clear = 1'b1;
      cyc();
    end
    clear = 1'b0;
    mSeq.delete();
    chk("abort_idle", 32'(busy), 32'(0));
    chk("abort_count", 32'(count), 32'(0));
    chk("abort_color", 32'(color_out), 32'(0));
    chk("abort_valid0", 32'(color_valid), 32'(0));
    chk("abort_nodone", 32'(done), 32'(0));
    chk("abort_ready", 32'(push_ready), 32'(1));
    cyc();
    chk("abort_nodone2", 32'(done), 32'(0));
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("abort_restart_done", 32'(done), 32'(1));
    chk("abort_restart_busy", 32'(busy), 32'(0));
    doReset();
    doPush(1);
    doPush(1);
    play(1'b0, 0, 2, 1, 12'hABC);
    doReset();
    doPush(1);
    play(1'b0, 0, 0, 0, 12'h000);
    doReset();
    doPush(3);
    play(1'b1, 2, 0, 0, 12'h000);
    for (int r = 0; r < 8; r++) begin
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      mSeq.delete();
      chk("rand_clear_count", 32'(count), 32'(0));
      palWrite($urandom_range(0, 3), 12'($urandom));
      palWrite($urandom_range(0, 3), 12'($urandom));
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) doPush($urandom_range(0, 3));
      wp = n == 0 ? 1'b1 : n == 4 ? 1'b0 : 1'($urandom_range(0, 1));
      play(wp, $urandom_range(0, 3), $urandom_range(1, (n > 0 ? n : 1) * PER), $urandom_range(0, 3), 12'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule

// File: doc/color_sequence_player.md
# color_sequence_player

Parametrised successor to the 2-bit colour converter for the Simon Says game. Stores a sequence of colour indices, maps each through a writable RGB palette, and plays the sequence back as timed colour flashes: each entry is shown for `ON_CYCLES`, followed by a blank for `OFF_CYCLES`. It sits between the game controller (which pushes sequence entries and requests playback) and the VGA/LED output path (which consumes the 12-bit colour).

## Interface
Parameters:
- `COLOR_BITS`, 2: colour index width. The palette has 2^`COLOR_BITS` entries.
- `CH_BITS`, 4: bits per R/G/B channel. The colour output is 3·`CH_BITS` bits, ordered {R,G,B}.
- `DEPTH`, 32: maximum sequence length.
- `ON_CYCLES`, 25_000_000: cycles each colour is shown. Must be ≥1.
- `OFF_CYCLES`, 12_500_000: blank cycles after each colour. Must be ≥1.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `push_valid` in 1: append `push_color` to the sequence.
- `push_color` in `COLOR_BITS`: palette index to append.
- `push_ready` out 1: high when in IDLE and count < `DEPTH`.
- `clear` in 1: empty the sequence and abort any playback.
- `start` in 1: begin playback of all stored entries.
- `pal_we` in 1: palette write strobe.
- `pal_addr` in `COLOR_BITS`: palette write index.
- `pal_data` in 3·`CH_BITS`: palette write data.
- `color_out` out 3·`CH_BITS`: current RGB value. Zero when not in ON.
- `color_valid` out 1: high during the ON phase.
- `step` out clog2(`DEPTH`): index of the entry being played.
- `count` out clog2(`DEPTH`+1): number of stored entries.
- `busy` out 1: high in ON or OFF.
- `done` out 1: one-cycle pulse when playback completes.

## Operation
- FSM states: IDLE, ON, OFF.
- **Reset values:**
  - All outputs are 0 except `push_ready`, which is 1.
  - State returns to IDLE.
  - Palette entries reset to: entry 0 = red F00, entry 1 = green 0F0, entry 2 = blue 00F, entry 3 = yellow FF0, all at full scale for `CH_BITS`. Entries ≥4 reset to all-ones (white). Entries that do not exist for small `COLOR_BITS` are omitted.
- **Push:** accepted when `push_valid && push_ready`. The entry is written at `seq[count]` and `count` increments.
  - Pushes while busy are ignored.
  - Pushes while full are ignored.
- **Start in IDLE with count > 0:**
  - The playback length L is latched as the post-push count, so a push in the same cycle is included.
  - `step` is set to 0.
  - The FSM enters ON.
- **Start in IDLE with count == 0 (and no push):** `done` pulses on the next cycle. The FSM stays in IDLE.
- **Start while busy:** ignored.
- **ON:**
  - `color_out` = palette[seq[step]]. It is latched on entry to ON, so a palette write during the step affects only later steps.
  - After `ON_CYCLES` cycles in ON, the FSM moves to OFF.
- **OFF:**
  - `color_out` = 0 and `color_valid` = 0.
  - After `OFF_CYCLES` cycles: if step == L−1, go to IDLE and pulse `done`. Otherwise increment `step` and go to ON.
- **Clear:**
  - Sets count = 0 in any state. It has priority over push and start.
  - If busy, the FSM goes to IDLE immediately, with no `done` pulse and with `color_out`/`color_valid` cleared.
- **Palette write:** `pal_we` writes on the rising edge. It is accepted in every state.
- **Sequence contents:** retained after playback, so the game replays and then extends the sequence.

## Timing
- All outputs are registered.
- `start` is sampled at edge 0. ON is visible from cycle 1, and `color_valid` is high in cycles 1..`ON_CYCLES`.
- Period per entry: `ON_CYCLES` + `OFF_CYCLES`.
- `done` is high in cycle L·(ON+OFF)+1, the first IDLE cycle. `busy` is low in that same cycle.
- `push_ready` drops in the cycle after a push that fills the sequence, or after start is accepted.
- Phase counter width is clog2(max(`ON_CYCLES`,`OFF_CYCLES`)). The counter reloads on every phase change.
- A reset asserted mid-playback takes effect at the next edge. There is no `done` pulse, and the palette returns to its defaults.

## Structure
- Package `simon_pkg` holds:
  - the FSM state enum {IDLE, ON, OFF};
  - the default palette constants RED, GREEN, BLUE, YELLOW, WHITE as 12-bit localparams, scaled by `CH_BITS` at use.
- Sub-module `color_palette` holds the 2^`COLOR_BITS` × 3·`CH_BITS` register array. It has:
  - a synchronous-reset write port;
  - a combinational read port.
- The sequence store is an in-module register array of `DEPTH` × `COLOR_BITS`.

## Test plan
Parameters for all scenarios: `ON_CYCLES`=3, `OFF_CYCLES`=2, `DEPTH`=4.
1. **Reset defaults:** push 0,1,2,3, then start. Required: `color_out` = F00×3, 0×2, 0F0×3, 0×2, 00F×3, 0×2, FF0×3, 0×2. `done` pulses at cycle 21. `step` walks 0..3.
2. **Full:** push 5 entries. Required: `count`=4, `push_ready`=0 after the 4th push, and the 5th push is ignored.
3. **Start with empty sequence:** start with count=0. Required: `done` pulses at cycle 1, `busy` never asserts, `color_valid` stays 0.
4. **Mid-playback abort:** assert `clear` in cycle 4 (OFF of entry 0). Required: next cycle IDLE, `count`=0, `color_out`=0, no `done` pulse. A later start gives an immediate `done` pulse.
5. **Palette write mid-step:** write `pal_addr`=1, `pal_data`=ABC while entry 0 is in ON, with sequence 1,1. Required: entry 0 keeps the old colour if it was already latched; entry 1 shows ABC. After that, a synchronous reset restores 0F0.
6. **Simultaneous push and start:** count=1, then `push_valid` and `start` in the same cycle. Required: L=2, and both entries are played.
